// File: rtl/dram_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : dram_rd_pkg                                                   |
// | Description: Shared types and constants for the 256x1 distributed-RAM      |
// |              stream reader (FSM states, RAM geometry, word-width limits).  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package dram_rd_pkg;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = 8;
  localparam int MAX_WIDTH = 32;

  // Bit counter only ever needs to index 0..MAX_WIDTH-1.
  localparam int BIT_CNT_W = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } rd_state_t;

endpackage : dram_rd_pkg
`default_nettype wire

// File: rtl/dram_rd_outbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dram_rd_outbuf                                                |
// | Description: Output word register with valid/ready handshake. Reports      |
// |              "free" when a new word may be loaded this cycle (empty, or    |
// |              the current word is being accepted). Optional parity output   |
// |              when DRAM_RD_PARITY_EN is defined.                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dram_rd_outbuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             free
`ifdef DRAM_RD_PARITY_EN
  ,
  output logic             par
`endif
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
`ifdef DRAM_RD_PARITY_EN
  logic             par_q, par_d;
`endif

  // A load is allowed in the same cycle the held word transfers, giving no gap.
  assign free = ~vld_q | rdy;

  // Next-state: load a new word, or drop valid once the held word is accepted.
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
`ifdef DRAM_RD_PARITY_EN
    par_d  = par_q;
`endif
    if (load) begin
      dout_d = word;
      vld_d  = 1'b1;
`ifdef DRAM_RD_PARITY_EN
      par_d  = ^word;
`endif
    end else if (vld_q && rdy) begin
      vld_d  = 1'b0;
    end
  end

  // Output register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
`ifdef DRAM_RD_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
`ifdef DRAM_RD_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  assign dout = dout_q;
  assign vld  = vld_q;
`ifdef DRAM_RD_PARITY_EN
  assign par  = par_q;
`endif

endmodule : dram_rd_outbuf
`default_nettype wire

// File: rtl/dram256_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dram256_stream_reader                                         |
// | Description: Walks the read port of a 256x1 distributed RAM from a start   |
// |              bit address, packs bits LSB-first into WIDTH-bit words and    |
// |              streams them out on a valid/ready interface.                  |
// |              Optional macro DRAM_RD_PARITY_EN adds the DOUT_PAR output.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dram256_stream_reader
  import dram_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [RAM_AW-1:0] START_ADDR,
  input  logic [RAM_AW-1:0] NWORDS,
  output logic [RAM_AW-1:0] DPRA,
  input  logic              DPO,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DOUT_VLD,
  input  logic              DOUT_RDY,
  output logic              BUSY,
  output logic              DONE
`ifdef DRAM_RD_PARITY_EN
  ,
  output logic              DOUT_PAR
`endif
);

  rd_state_t              state_q, state_d;
  logic [RAM_AW-1:0]      dpra_q, dpra_d;
  logic [RAM_AW:0]        word_cnt_q, word_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic                   done_q, done_d;

  logic                   ob_load;
  logic [WIDTH-1:0]       ob_word;
  logic                   ob_free;
  logic [WIDTH-1:0]       bit_mask;
  logic [WIDTH-1:0]       packed_word;
  logic                   word_full;

  // Current bit lands at position bit_cnt; packed_word is the shift register
  // including the bit being sampled this cycle.
  assign bit_mask    = WIDTH'(1) << bit_cnt_q;
  assign packed_word = (shift_q & ~bit_mask) | (DPO ? bit_mask : '0);
  assign word_full   = (bit_cnt_q == BIT_CNT_W'(WIDTH - 1));

  // Next-state and datapath control for the read FSM.
  always_comb begin
    state_d    = state_q;
    dpra_d     = dpra_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    ob_load    = 1'b0;
    ob_word    = shift_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          dpra_d     = START_ADDR;
          word_cnt_d = (NWORDS == '0) ? (RAM_AW+1)'(RAM_DEPTH) : {1'b0, NWORDS};
          bit_cnt_d  = '0;
          shift_d    = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        dpra_d = dpra_q + 1'b1;
        if (word_full) begin
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q - 1'b1;
          if (ob_free) begin
            ob_load = 1'b1;
            ob_word = packed_word;
            shift_d = '0;
            state_d = (word_cnt_q == 1) ? DRAIN : SHIFT;
          end else begin
            shift_d = packed_word;
            state_d = HOLD;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = packed_word;
        end
      end
      HOLD: begin
        // Output register is occupied, so free here means it is being accepted.
        if (ob_free) begin
          ob_load = 1'b1;
          ob_word = shift_q;
          shift_d = '0;
          state_d = (word_cnt_q == '0) ? DRAIN : SHIFT;
        end
      end
      DRAIN: begin
        if (DOUT_VLD && DOUT_RDY) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address, counters and shift register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      dpra_q     <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dpra_q     <= dpra_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
    end
  end

  dram_rd_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk  (CLK),
    .rst  (RST),
    .load (ob_load),
    .word (ob_word),
    .rdy  (DOUT_RDY),
    .dout (DOUT),
    .vld  (DOUT_VLD),
    .free (ob_free)
`ifdef DRAM_RD_PARITY_EN
    ,
    .par  (DOUT_PAR)
`endif
  );

  assign DPRA = dpra_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;

endmodule : dram256_stream_reader
`default_nettype wire

// File: tb/tb_dram256_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_dram256_stream_reader                                      |
// | Description: Scoreboard bench for dram256_stream_reader. The RAM is a      |
// |              256-bit array with combinational read. Define                 |
// |              DRAM_RD_PARITY_EN to also check DOUT_PAR.                     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dram256_stream_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  START_ADDR;
  logic [7:0]  NWORDS;
  logic [7:0]  DPRA;
  logic        DPO;
  logic [7:0]  DOUT;
  logic        DOUT_VLD;
  logic        DOUT_RDY;
  logic        BUSY;
  logic        DONE;
`ifdef DRAM_RD_PARITY_EN
  logic        DOUT_PAR;
`endif

  logic [255:0] ram;
  assign DPO = ram[DPRA];

  always #5 CLK = ~CLK;

  dram256_stream_reader #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .START_ADDR (START_ADDR),
    .NWORDS     (NWORDS),
    .DPRA       (DPRA),
    .DPO        (DPO),
    .DOUT       (DOUT),
    .DOUT_VLD   (DOUT_VLD),
    .DOUT_RDY   (DOUT_RDY),
    .BUSY       (BUSY),
    .DONE       (DONE)
`ifdef DRAM_RD_PARITY_EN
    ,
    .DOUT_PAR   (DOUT_PAR)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] word;
    logic       par;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w, input logic p);
    exp_t e;
    e.word = w;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold stability.
  exp_t       mon_exp;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dout  = '0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", 32'(DOUT_VLD), 32'd1);
        check("hold_dout", 32'(DOUT), 32'(prev_dout));
      end
      if (DOUT_VLD && DOUT_RDY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h, expected none", DOUT);
        end else begin
          mon_exp = exp_q.pop_front();
          check("dout", 32'(DOUT), 32'(mon_exp.word));
`ifdef DRAM_RD_PARITY_EN
          check("dout_par", 32'(DOUT_PAR), 32'(mon_exp.par));
`endif
        end
      end
      prev_stall = DOUT_VLD && !DOUT_RDY;
      prev_dout  = DOUT;
    end
  end

  task automatic start_cmd(input logic [7:0] addr, input logic [7:0] n);
    @(posedge CLK); #1;
    START      = 1'b1;
    START_ADDR = addr;
    NWORDS     = n;
    @(posedge CLK); #1;
    START      = 1'b0;
  endtask

  // Counts BUSY cycles until DONE; optionally checks DPRA for the first ndpra cycles.
  task automatic wait_done(input string name, input int exp_busy, input int ndpra, input logic [7:0] base);
    int         cnt  = 0;
    bit         seen = 1'b0;
    logic [7:0] a;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (i < ndpra) begin
        a = base + 8'(i);
        check({name, "_dpra"}, 32'(DPRA), 32'(a));
      end
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (BUSY) cnt++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no DONE, expected DONE within 5000 cycles", name);
    end else begin
      if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
      check({name, "_busy_at_done"}, 32'(BUSY), 32'd0);
      @(negedge CLK);
      check({name, "_done_pulse"}, 32'(DONE), 32'd0);
    end
  endtask

  initial begin
    RST        = 1'b1;
    START      = 1'b0;
    START_ADDR = '0;
    NWORDS     = '0;
    DOUT_RDY   = 1'b0;
    ram        = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dpra", 32'(DPRA), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_vld",  32'(DOUT_VLD), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
`ifdef DRAM_RD_PARITY_EN
    check("rst_par",  32'(DOUT_PAR), 32'd0);
`endif
    RST = 1'b0;

    // Two words from address 0, no back-pressure.
    ram[15:0] = 16'h3CA5;
    DOUT_RDY  = 1'b1;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    start_cmd(8'd0, 8'd2);
    wait_done("t1", 17, 0, 8'd0);

    // Address wrap 252..255,0..3.
    ram          = '0;
    ram[255:252] = 4'hB;
    ram[3:0]     = 4'h6;
    push(8'h6B, 1'b1);
    start_cmd(8'd252, 8'd1);
    wait_done("t2", 9, 8, 8'd252);

    // Back-pressure: three words, RDY low for 20 cycles.
    ram       = '0;
    ram[23:0] = 24'h3D3CA5;
    DOUT_RDY  = 1'b0;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    push(8'h3D, 1'b1);
    start_cmd(8'd0, 8'd3);
    repeat (20) @(negedge CLK);
    check("t3_stall_dout", 32'(DOUT), 32'hA5);
    check("t3_stall_vld",  32'(DOUT_VLD), 32'd1);
    check("t3_stall_dpra", 32'(DPRA), 32'd16);
    check("t3_stall_busy", 32'(BUSY), 32'd1);
    @(posedge CLK); #1;
    DOUT_RDY = 1'b1;
    wait_done("t3", -1, 0, 8'd0);

    // NWORDS=0 reads 256 words: the RAM eight times over.
    ram = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
           64'hA5A55A5A0FF0C33C, 64'h13579BDF2468ACE0};
    for (int w = 0; w < 256; w++) push(ram[8*(w%32) +: 8], ^ram[8*(w%32) +: 8]);
    start_cmd(8'd0, 8'd0);
    wait_done("t4", 2049, 0, 8'd0);

    // START while busy is ignored.
    ram       = '0;
    ram[15:0] = 16'h3CA5;
    push(8'hA5, 1'b0);
    start_cmd(8'd0, 8'd1);
    @(posedge CLK); #1;
    START      = 1'b1;
    START_ADDR = 8'd100;
    NWORDS     = 8'd5;
    @(posedge CLK); #1;
    START      = 1'b0;
    wait_done("t5_busy_start", 7, 0, 8'd0);

    // Asynchronous reset mid-SHIFT aborts with no DONE.
    start_cmd(8'd0, 8'd2);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("t5_rst_dpra", 32'(DPRA), 32'd0);
    check("t5_rst_dout", 32'(DOUT), 32'd0);
    check("t5_rst_vld",  32'(DOUT_VLD), 32'd0);
    check("t5_rst_busy", 32'(BUSY), 32'd0);
    check("t5_rst_done", 32'(DONE), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check("t5_rst_hold_done", 32'(DONE), 32'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("t5_post_rst_done", 32'(DONE), 32'd0);
    check("t5_post_rst_busy", 32'(BUSY), 32'd0);

    // Fresh command after reset runs normally.
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    start_cmd(8'd0, 8'd2);
    wait_done("t5_after_rst", 17, 0, 8'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dram256_stream_reader
`default_nettype wire
